uart_core: RTL

Parametrised UART engine: a baud-tick generator, a TX serialiser, and an oversampling RX deserialiser, each channel buffered by its own internal FIFO. Replaces the bare two-FIFO top as the block the system bus talks to. Host logic pushes bytes to the TX FIFO and pops received bytes from the RX FIFO; `txd`/`rxd` connect to the pins.

---
 rtl/uart_core.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_core.sv
// uart_core: baud-tick generator, TX serialiser, oversampling RX deserialiser,
// each channel buffered by its own DEPTH-entry FIFO.
// Ports: clk, rst (async active-low); baud_div (tick every baud_div+1 clocks);
//   TX side: tx_wr_en/tx_data_in push, tx_full, tx_count, tx_busy, txd pin;
//   RX side: rxd pin, rx_rd_en pop, rx_data_out (registered), rx_empty, rx_count;
//   errors: err_clr, sticky rx_frame_err / rx_overrun / rx_parity_err.
// Optional macro UART_PARITY_EN adds a parity bit (parity_odd selects odd);
// without it frames are start + D_W + stop and rx_parity_err is tied 0.
module uart_core #(
    parameter int D_W    = 8,
    parameter int B_TICK = 16,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic                     parity_odd,
    input  logic                     tx_wr_en,
    input  logic [D_W-1:0]           tx_data_in,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_busy,
    output logic                     txd,
    input  logic                     rxd,
    input  logic                     rx_rd_en,
    output logic [D_W-1:0]           rx_data_out,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   rx_count,
    input  logic                     err_clr,
    output logic                     rx_frame_err,
    output logic                     rx_overrun,
    output logic                     rx_parity_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(B_TICK);
    localparam int BW = $clog2(D_W);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;

    // ---------------- baud generator ----------------
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             tick;

    // ">=" keeps the counter from running away if baud_div is lowered live
    always_comb begin
        tick       = (baud_cnt_q >= baud_div);
        baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    end

    // ---------------- TX FIFO + FSM ----------------
    logic [D_W-1:0] tx_mem [DEPTH];
    logic [AW:0]    tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic           tx_empty, tx_push, tx_load, tx_bit_end;
    logic [D_W-1:0] tx_head;
    state_t         tx_st_q, tx_st_d;
    logic [TW-1:0]  tx_tcnt_q, tx_tcnt_d;
    logic [BW-1:0]  tx_bcnt_q, tx_bcnt_d;
    logic [D_W-1:0] tx_sh_q, tx_sh_d;
    logic           txd_q, txd_d;
`ifdef UART_PARITY_EN
    logic           tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_empty = (tx_wp_q == tx_rp_q);
        tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                   (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
        tx_count = tx_wp_q - tx_rp_q;
        tx_push  = tx_wr_en && !tx_full;
        tx_head  = tx_mem[tx_rp_q[AW-1:0]];
        tx_busy  = (tx_st_q != ST_IDLE);
        txd      = txd_q;
    end

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_sh_d    = tx_sh_q;
        tx_load    = 1'b0;
        txd_d      = 1'b1;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        tx_bit_end = tick && (tx_tcnt_q == TW'(B_TICK - 1));
        if (tick) tx_tcnt_d = tx_tcnt_q + 1'b1;
        unique case (tx_st_q)
            ST_IDLE: tx_load = !tx_empty;
            ST_START: if (tx_bit_end) begin
                tx_st_d   = ST_DATA;
                tx_tcnt_d = '0;
                tx_bcnt_d = '0;
            end
            ST_DATA: if (tx_bit_end) begin
                tx_tcnt_d = '0;
                tx_sh_d   = tx_sh_q >> 1;
                tx_bcnt_d = tx_bcnt_q + 1'b1;
                if (tx_bcnt_q == BW'(D_W - 1)) begin
`ifdef UART_PARITY_EN
                    tx_st_d = ST_PARITY;
`else
                    tx_st_d = ST_STOP;
`endif
                end
            end
            ST_PARITY: if (tx_bit_end) begin
                tx_tcnt_d = '0;
                tx_st_d   = ST_STOP;
            end
            ST_STOP: if (tx_bit_end) begin
                tx_tcnt_d = '0;
                tx_st_d   = ST_IDLE;
                // chain straight into the next frame: no idle gap
                tx_load   = !tx_empty;
            end
            default: tx_st_d = ST_IDLE;
        endcase
        if (tx_load) begin
            tx_st_d   = ST_START;
            tx_tcnt_d = '0;
            tx_sh_d   = tx_head;
`ifdef UART_PARITY_EN
            tx_par_d  = (^tx_head) ^ parity_odd;
`endif
        end
        unique case (tx_st_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
            ST_PARITY: txd_d = tx_par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
        tx_wp_d = tx_wp_q + {{AW{1'b0}}, tx_push};
        tx_rp_d = tx_rp_q + {{AW{1'b0}}, tx_load};
    end

    // ---------------- RX sync, FSM, FIFO ----------------
    logic           sync1_q, sync2_q;
    state_t         rx_st_q, rx_st_d;
    logic [TW-1:0]  rx_tcnt_q, rx_tcnt_d;
    logic [BW-1:0]  rx_bcnt_q, rx_bcnt_d;
    logic [D_W-1:0] rx_sh_q, rx_sh_d;
    logic           rx_bit_end, rx_half, par_bad;
    logic           rx_push, rx_pop, rx_full;
    logic           set_frame, set_over, set_par;
    logic [D_W-1:0] rx_mem [DEPTH];
    logic [AW:0]    rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [D_W-1:0] rx_dout_q, rx_dout_d;
    logic           frame_q, frame_d, over_q, over_d;
`ifdef UART_PARITY_EN
    logic           rx_par_q, rx_par_d, perr_q, perr_d;
`else
    logic           unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_comb begin
        rx_empty = (rx_wp_q == rx_rp_q);
        rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                   (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
        rx_count = rx_wp_q - rx_rp_q;
        rx_pop   = rx_rd_en && !rx_empty;
`ifdef UART_PARITY_EN
        par_bad  = rx_par_q != ((^rx_sh_q) ^ parity_odd);
`else
        par_bad  = 1'b0;
`endif
    end

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        set_frame  = 1'b0;
        set_over   = 1'b0;
        set_par    = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
`endif
        rx_bit_end = tick && (rx_tcnt_q == TW'(B_TICK - 1));
        rx_half    = tick && (rx_tcnt_q == TW'(B_TICK / 2 - 1));
        if (tick) rx_tcnt_d = rx_tcnt_q + 1'b1;
        unique case (rx_st_q)
            ST_IDLE: if (!sync2_q) begin
                rx_st_d   = ST_START;
                rx_tcnt_d = '0;
            end
            // half-bit check moves all later samples to mid-bit
            ST_START: if (rx_half) begin
                rx_tcnt_d = '0;
                rx_bcnt_d = '0;
                rx_st_d   = sync2_q ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (rx_bit_end) begin
                rx_tcnt_d = '0;
                rx_sh_d   = {sync2_q, rx_sh_q[D_W-1:1]};
                rx_bcnt_d = rx_bcnt_q + 1'b1;
                if (rx_bcnt_q == BW'(D_W - 1)) begin
`ifdef UART_PARITY_EN
                    rx_st_d = ST_PARITY;
`else
                    rx_st_d = ST_STOP;
`endif
                end
            end
            ST_PARITY: if (rx_bit_end) begin
                rx_tcnt_d = '0;
                rx_st_d   = ST_STOP;
`ifdef UART_PARITY_EN
                rx_par_d  = sync2_q;
`endif
            end
            ST_STOP: if (rx_bit_end) begin
                rx_tcnt_d = '0;
                rx_st_d   = ST_IDLE;
                if (!sync2_q)     set_frame = 1'b1;
                else if (par_bad) set_par   = 1'b1;
                else if (rx_full) set_over  = 1'b1;
                else              rx_push   = 1'b1;
            end
            default: rx_st_d = ST_IDLE;
        endcase
        rx_wp_d   = rx_wp_q + {{AW{1'b0}}, rx_push};
        rx_rp_d   = rx_rp_q + {{AW{1'b0}}, rx_pop};
        rx_dout_d = rx_pop ? rx_mem[rx_rp_q[AW-1:0]] : rx_dout_q;
        frame_d   = set_frame | (frame_q & ~err_clr);
        over_d    = set_over | (over_q & ~err_clr);
`ifdef UART_PARITY_EN
        perr_d    = set_par | (perr_q & ~err_clr);
`endif
    end

    always_comb begin
        rx_data_out  = rx_dout_q;
        rx_frame_err = frame_q;
        rx_overrun   = over_q;
`ifdef UART_PARITY_EN
        rx_parity_err = perr_q;
`else
        rx_parity_err = set_par;
`endif
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= tx_data_in;
        if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt_q <= '0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_st_q    <= ST_IDLE;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_st_q    <= ST_IDLE;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_sh_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_dout_q  <= '0;
            frame_q    <= 1'b0;
            over_q     <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
            rx_par_q   <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            baud_cnt_q <= baud_cnt_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_st_q    <= tx_st_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            sync1_q    <= rxd;
            sync2_q    <= sync1_q;
            rx_st_q    <= rx_st_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bcnt_q  <= rx_bcnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_dout_q  <= rx_dout_d;
            frame_q    <= frame_d;
            over_q     <= over_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
            rx_par_q   <= rx_par_d;
            perr_q     <= perr_d;
`endif
        end
    end
endmodule
